// File: rtl/degearbox.sv
// Serial-to-parallel receiver: shifts in one bit per ref_clk (LSB first), aligns on a
// comma token and emits one DATA_OUT_SIZE-bit word every DATA_OUT_SIZE cycles while locked.
module degearbox #(
    parameter int                       DATA_OUT_SIZE  = 10,
    parameter logic [DATA_OUT_SIZE-1:0] COMMA          = 10'b1101010100,
    parameter bit                       MATCH_INVERTED = 1'b1,
    parameter int                       MISALIGN_LIMIT = 3
) (
    input  logic                     ref_clk,
    input  logic                     rst_n,
    input  logic                     data_in,
    output logic [DATA_OUT_SIZE-1:0] data_out,
    output logic                     data_valid,
    output logic                     comma_det,
    output logic                     locked
);

    localparam int         N     = DATA_OUT_SIZE;
    localparam logic [3:0] LAST  = 4'(N - 1);
    localparam logic [3:0] LIMIT = 4'(MISALIGN_LIMIT);

    typedef enum logic {
        HUNT,
        SYNC
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] sr;
    logic [N-1:0] window;
    logic [N-1:0] data_next;
    logic [3:0]   phase;
    logic [3:0]   phase_next;
    logic [3:0]   misalign;
    logic [3:0]   misalign_next;
    logic [3:0]   misalign_inc;
    logic         valid_next;
    logic         comma_next;
    logic         match;
    logic         boundary;

    // The window includes the bit arriving this edge, so a word is captured on its last bit.
    assign window       = {data_in, sr[N-1:1]};
    assign match        = (window == COMMA) || (MATCH_INVERTED && (window == ~COMMA));
    assign boundary     = (phase == LAST);
    assign misalign_inc = (misalign == 4'hF) ? 4'hF : misalign + 4'd1;
    assign locked       = (state == SYNC);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sr         <= '0;
            phase      <= '0;
            misalign   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            comma_det  <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= window;
            phase      <= phase_next;
            misalign   <= misalign_next;
            data_out   <= data_next;
            data_valid <= valid_next;
            comma_det  <= comma_next;
        end
    end

    always_comb begin
        state_next    = state;
        phase_next    = phase;
        misalign_next = misalign;
        data_next     = data_out;
        valid_next    = 1'b0;
        comma_next    = 1'b0;
        case (state)
            HUNT: begin
                if (match) begin
                    state_next    = SYNC;
                    phase_next    = '0;
                    misalign_next = '0;
                    data_next     = window;
                    valid_next    = 1'b1;
                    comma_next    = 1'b1;
                end
            end
            SYNC: begin
                phase_next = boundary ? 4'd0 : phase + 4'd1;
                if (boundary) begin
                    data_next  = window;
                    valid_next = 1'b1;
                    comma_next = match;
                    if (match) begin
                        misalign_next = '0;
                    end
                end else if (match) begin
                    // Only off-phase commas count; ordinary data never clears the tally.
                    misalign_next = misalign_inc;
                    if (misalign_inc >= LIMIT) begin
                        state_next = HUNT;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_degearbox.sv
// Directed bench for degearbox: default 10-bit instance, an exact-match-only instance
// and a 16-bit instance, driven bit-serially with hand-computed expected words.
module tb_degearbox;

    logic        clk;
    logic        rst_n;
    logic        din_a;
    logic        din_b;
    logic        din_c;
    logic [9:0]  data_out_a;
    logic [9:0]  data_out_b;
    logic [15:0] data_out_c;
    logic        valid_a, valid_b, valid_c;
    logic        comma_a, comma_b, comma_c;
    logic        locked_a, locked_b, locked_c;
    logic [2:0]  valid_v;
    logic [2:0]  comma_v;
    logic [2:0]  locked_v;

    int compared;
    int mismatched;
    int cyc;
    int pulses[3];
    int last_pulse[3];
    int prev_pulse[3];

    typedef struct {
        int          sel;
        logic [15:0] word;
        int          nbits;
        logic [15:0] exp_data;
        logic        exp_comma;
        int          exp_gap;
    } vec_t;

    vec_t vecs[11];

    degearbox #(.DATA_OUT_SIZE(10)) dut_a (
        .ref_clk(clk), .rst_n(rst_n), .data_in(din_a), .data_out(data_out_a),
        .data_valid(valid_a), .comma_det(comma_a), .locked(locked_a)
    );

    degearbox #(.DATA_OUT_SIZE(10), .MATCH_INVERTED(1'b0)) dut_b (
        .ref_clk(clk), .rst_n(rst_n), .data_in(din_b), .data_out(data_out_b),
        .data_valid(valid_b), .comma_det(comma_b), .locked(locked_b)
    );

    degearbox #(.DATA_OUT_SIZE(16), .COMMA(16'hF0A5)) dut_c (
        .ref_clk(clk), .rst_n(rst_n), .data_in(din_c), .data_out(data_out_c),
        .data_valid(valid_c), .comma_det(comma_c), .locked(locked_c)
    );

    assign valid_v  = {valid_c, valid_b, valid_a};
    assign comma_v  = {comma_c, comma_b, comma_a};
    assign locked_v = {locked_c, locked_b, locked_a};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] out_of(input int sel);
        case (sel)
            0:       return {6'd0, data_out_a};
            1:       return {6'd0, data_out_b};
            default: return data_out_c;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Shift nbits of word into the selected instance LSB first, logging every valid pulse.
    task automatic apply_stimulus(input int sel, input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            case (sel)
                0:       din_a = word[i];
                1:       din_b = word[i];
                default: din_c = word[i];
            endcase
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (valid_v[k]) begin
                    pulses[k]++;
                    prev_pulse[k] = last_pulse[k];
                    last_pulse[k] = cyc;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        din_a = 1'b0;
        din_b = 1'b0;
        din_c = 1'b0;
    endtask

    // Send one word and expect exactly one pulse, landing on its final bit.
    task automatic send_expect(input string name, input int sel, input logic [15:0] word, input int nbits,
                               input logic [15:0] exp_data, input logic exp_comma, input int exp_gap);
        int p0;
        p0 = pulses[sel];
        apply_stimulus(sel, word, nbits);
        check_output({name, "_pulse_count"}, 32'(pulses[sel] - p0), 32'd1);
        check_output({name, "_pulse_on_last_bit"}, 32'(last_pulse[sel]), 32'(cyc));
        check_output({name, "_data"}, {16'd0, out_of(sel)}, {16'd0, exp_data});
        check_output({name, "_comma_det"}, {31'd0, comma_v[sel]}, {31'd0, exp_comma});
        check_output({name, "_locked"}, {31'd0, locked_v[sel]}, 32'd1);
        if (exp_gap > 0) begin
            check_output({name, "_gap"}, 32'(last_pulse[sel] - prev_pulse[sel]), 32'(exp_gap));
        end
    endtask

    initial begin
        int p0;
        int p1;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        for (int k = 0; k < 3; k++) begin
            pulses[k]     = 0;
            last_pulse[k] = 0;
            prev_pulse[k] = 0;
        end
        rst_n = 1'b0;
        din_a = 1'b0;
        din_b = 1'b0;
        din_c = 1'b0;

        vecs[0]  = '{0, 16'h0354, 10, 16'h0354, 1'b1, 0};
        vecs[1]  = '{0, 16'h02AB, 10, 16'h02AB, 1'b0, 10};
        vecs[2]  = '{0, 16'h01F0, 10, 16'h01F0, 1'b0, 10};
        vecs[3]  = '{0, 16'h0354, 10, 16'h0354, 1'b1, 10};
        vecs[4]  = '{0, 16'h0000, 10, 16'h0000, 1'b0, 10};
        vecs[5]  = '{0, 16'h03FF, 10, 16'h03FF, 1'b0, 10};
        vecs[6]  = '{2, 16'hF0A5, 16, 16'hF0A5, 1'b1, 0};
        vecs[7]  = '{2, 16'h1234, 16, 16'h1234, 1'b0, 16};
        vecs[8]  = '{2, 16'hBEEF, 16, 16'hBEEF, 1'b0, 16};
        vecs[9]  = '{2, 16'hF0A5, 16, 16'hF0A5, 1'b1, 16};
        vecs[10] = '{2, 16'h0000, 16, 16'h0000, 1'b0, 16};

        #2;
        check_output("reset_data_out", {22'd0, data_out_a}, 32'd0);
        check_output("reset_valid", {31'd0, valid_a}, 32'd0);
        check_output("reset_comma", {31'd0, comma_a}, 32'd0);
        check_output("reset_locked", {31'd0, locked_a}, 32'd0);
        #21 rst_n = 1'b1;

        p0 = pulses[0];
        apply_stimulus(0, 16'h0000, 20);
        check_output("idle_no_pulse", 32'(pulses[0] - p0), 32'd0);
        check_output("idle_locked", {31'd0, locked_a}, 32'd0);
        check_output("idle_data_out", {22'd0, data_out_a}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            send_expect($sformatf("vec%0d", i), vecs[i].sel, vecs[i].word, vecs[i].nbits,
                        vecs[i].exp_data, vecs[i].exp_comma, vecs[i].exp_gap);
        end

        // Inverted comma locks only when MATCH_INVERTED is set.
        pulse_reset();
        send_expect("inv_lock", 0, 16'h00AB, 10, 16'h00AB, 1'b1, 0);
        p0 = pulses[1];
        apply_stimulus(1, 16'h00AB, 10);
        check_output("exact_only_no_pulse", 32'(pulses[1] - p0), 32'd0);
        check_output("exact_only_locked", {31'd0, locked_b}, 32'd0);

        // Three commas three bits off-phase drop lock; the next comma relocks.
        pulse_reset();
        send_expect("mis_lock", 0, 16'h0354, 10, 16'h0354, 1'b1, 0);
        apply_stimulus(0, 16'h0000, 3);
        apply_stimulus(0, 16'h0354, 10);
        check_output("mis_after1_locked", {31'd0, locked_a}, 32'd1);
        apply_stimulus(0, 16'h0354, 10);
        check_output("mis_after2_locked", {31'd0, locked_a}, 32'd1);
        apply_stimulus(0, 16'h0354, 10);
        check_output("mis_after3_locked", {31'd0, locked_a}, 32'd0);
        check_output("mis_after3_valid", {31'd0, valid_a}, 32'd0);
        send_expect("mis_relock", 0, 16'h0354, 10, 16'h0354, 1'b1, 0);
        send_expect("mis_word", 0, 16'h02AB, 10, 16'h02AB, 1'b0, 10);

        // Two off-phase commas then an aligned one keep lock and clear the tally.
        pulse_reset();
        send_expect("clr_lock", 0, 16'h0354, 10, 16'h0354, 1'b1, 0);
        apply_stimulus(0, 16'h0000, 3);
        apply_stimulus(0, 16'h0354, 10);
        apply_stimulus(0, 16'h0354, 10);
        apply_stimulus(0, 16'h0000, 7);
        send_expect("clr_aligned", 0, 16'h0354, 10, 16'h0354, 1'b1, 10);
        apply_stimulus(0, 16'h0000, 3);
        apply_stimulus(0, 16'h0354, 10);
        apply_stimulus(0, 16'h0354, 10);
        check_output("clr_still_locked", {31'd0, locked_a}, 32'd1);

        // Asynchronous reset in the middle of a word, then relock only on a fresh comma.
        pulse_reset();
        send_expect("rst_lock", 0, 16'h0354, 10, 16'h0354, 1'b1, 0);
        apply_stimulus(0, 16'h02AB, 5);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_data_out", {22'd0, data_out_a}, 32'd0);
        check_output("async_rst_locked", {31'd0, locked_a}, 32'd0);
        check_output("async_rst_valid", {31'd0, valid_a}, 32'd0);
        check_output("async_rst_comma", {31'd0, comma_a}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        p1 = pulses[0];
        apply_stimulus(0, 16'h02AB, 10);
        apply_stimulus(0, 16'h01F0, 10);
        check_output("post_rst_no_pulse", 32'(pulses[0] - p1), 32'd0);
        check_output("post_rst_locked", {31'd0, locked_a}, 32'd0);
        send_expect("post_rst_relock", 0, 16'h0354, 10, 16'h0354, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
